// File: rtl/id_ex_alu_ctrl_if.sv
// -----------------------------------------------------------------------------
// id_ex_alu_ctrl_if
// Bundles the ID-side instruction/handshake signals and the EX-side operation
// outputs of the ID/EX ALU-control stage.
//   slave  : view taken by id_ex_alu_ctrl (consumes i_*, produces o_*)
//   master : view taken by the surrounding pipeline / testbench
// Signals:
//   i_valid, o_ready         upstream handshake
//   i_opcode, i_funct,
//   i_shamt, i_imm           instruction fields
//   i_rs_data, i_rt_data     register-file read values
//   i_ready, o_valid         downstream handshake
//   i_flush                  squash the stage
//   o_alu_opcode, o_data_a,
//   o_data_b, o_illegal      registered ALU operation
//   o_illegal_cnt            only when ALU_CTRL_ILLCNT_EN is defined
// -----------------------------------------------------------------------------
interface id_ex_alu_ctrl_if #(
  parameter int NB_DATA        = 32,
  parameter int N_BITS_CONTROL = 5,
  parameter int NB_CNT         = 16
);
  logic                      i_valid;
  logic                      o_ready;
  logic [5:0]                i_opcode;
  logic [5:0]                i_funct;
  logic [4:0]                i_shamt;
  logic [15:0]               i_imm;
  logic [NB_DATA-1:0]        i_rs_data;
  logic [NB_DATA-1:0]        i_rt_data;
  logic                      i_ready;
  logic                      i_flush;
  logic                      o_valid;
  logic [N_BITS_CONTROL-1:0] o_alu_opcode;
  logic [NB_DATA-1:0]        o_data_a;
  logic [NB_DATA-1:0]        o_data_b;
  logic                      o_illegal;
`ifdef ALU_CTRL_ILLCNT_EN
  logic [NB_CNT-1:0]         o_illegal_cnt;

  modport slave (
    input  i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
           i_ready, i_flush,
    output o_ready, o_valid, o_alu_opcode, o_data_a, o_data_b, o_illegal,
           o_illegal_cnt
  );

  modport master (
    output i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
           i_ready, i_flush,
    input  o_ready, o_valid, o_alu_opcode, o_data_a, o_data_b, o_illegal,
           o_illegal_cnt
  );
`else
  modport slave (
    input  i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
           i_ready, i_flush,
    output o_ready, o_valid, o_alu_opcode, o_data_a, o_data_b, o_illegal
  );

  modport master (
    output i_valid, i_opcode, i_funct, i_shamt, i_imm, i_rs_data, i_rt_data,
           i_ready, i_flush,
    input  o_ready, o_valid, o_alu_opcode, o_data_a, o_data_b, o_illegal
  );
`endif
endinterface

// File: rtl/id_ex_alu_ctrl.sv
// -----------------------------------------------------------------------------
// id_ex_alu_ctrl
// ID/EX pipeline stage that decodes a MIPS opcode/funct into the 5-bit ALU
// operation code and selects/extends the two ALU operands, registering them
// for the EX stage behind a valid/ready handshake with stall and flush.
//
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous, active-high reset
//   bus      id_ex_alu_ctrl_if.slave (handshake, instruction fields, operands,
//            registered ALU operation and illegal flag)
//
// Optional build macro ALU_CTRL_ILLCNT_EN: adds a saturating NB_CNT-bit count
// of illegal instructions loaded (bus.o_illegal_cnt), cleared only by reset.
// -----------------------------------------------------------------------------
module id_ex_alu_ctrl #(
  parameter int NB_DATA        = 32,
  parameter int N_BITS_CONTROL = 5,
  parameter int NB_CNT         = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  id_ex_alu_ctrl_if.slave      bus
);

  // ALU operation codes
  localparam logic [N_BITS_CONTROL-1:0] ALU_AND     = N_BITS_CONTROL'(5'b00000);
  localparam logic [N_BITS_CONTROL-1:0] ALU_OR      = N_BITS_CONTROL'(5'b00001);
  localparam logic [N_BITS_CONTROL-1:0] ALU_ADD     = N_BITS_CONTROL'(5'b00010);
  localparam logic [N_BITS_CONTROL-1:0] ALU_ADDU    = N_BITS_CONTROL'(5'b00011);
  localparam logic [N_BITS_CONTROL-1:0] ALU_NOR     = N_BITS_CONTROL'(5'b00100);
  localparam logic [N_BITS_CONTROL-1:0] ALU_XOR     = N_BITS_CONTROL'(5'b00101);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SLL     = N_BITS_CONTROL'(5'b00110);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SUB     = N_BITS_CONTROL'(5'b00111);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SUBU    = N_BITS_CONTROL'(5'b01000);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SLT     = N_BITS_CONTROL'(5'b01001);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SRL     = N_BITS_CONTROL'(5'b01010);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SRA     = N_BITS_CONTROL'(5'b01011);
  localparam logic [N_BITS_CONTROL-1:0] ALU_LUI     = N_BITS_CONTROL'(5'b01100);
  localparam logic [N_BITS_CONTROL-1:0] ALU_LB      = N_BITS_CONTROL'(5'b01101);
  localparam logic [N_BITS_CONTROL-1:0] ALU_LH      = N_BITS_CONTROL'(5'b01110);
  localparam logic [N_BITS_CONTROL-1:0] ALU_LBU     = N_BITS_CONTROL'(5'b01111);
  localparam logic [N_BITS_CONTROL-1:0] ALU_LHU     = N_BITS_CONTROL'(5'b10000);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SRAV    = N_BITS_CONTROL'(5'b10001);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SLLV    = N_BITS_CONTROL'(5'b10010);
  localparam logic [N_BITS_CONTROL-1:0] ALU_SRLV    = N_BITS_CONTROL'(5'b10011);
  localparam logic [N_BITS_CONTROL-1:0] ALU_ILLEGAL = '1;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_LB    = 6'b100000;
  localparam logic [5:0] OPC_LH    = 6'b100001;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_LBU   = 6'b100100;
  localparam logic [5:0] OPC_LHU   = 6'b100101;
  localparam logic [5:0] OPC_SB    = 6'b101000;
  localparam logic [5:0] OPC_SH    = 6'b101001;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef enum logic [1:0] {
    A_RS,
    A_RT,
    A_ZERO
  } a_sel_e;

  typedef enum logic [2:0] {
    B_RT,
    B_SHAMT,
    B_SEXT,
    B_ZEXT,
    B_ZERO
  } b_sel_e;

  function automatic logic [NB_DATA-1:0] sext16(input logic [15:0] v);
    return {{(NB_DATA-16){v[15]}}, v};
  endfunction

  function automatic logic [NB_DATA-1:0] zext16(input logic [15:0] v);
    return {{(NB_DATA-16){1'b0}}, v};
  endfunction

  function automatic logic [NB_DATA-1:0] zext5(input logic [4:0] v);
    return {{(NB_DATA-5){1'b0}}, v};
  endfunction

  // Decode (combinational, ahead of the stage register)
  a_sel_e                    a_sel;
  b_sel_e                    b_sel;
  logic [N_BITS_CONTROL-1:0] dec_op;
  logic                      dec_illegal;
  logic [NB_DATA-1:0]        dec_a;
  logic [NB_DATA-1:0]        dec_b;

  always_comb begin
    dec_op      = ALU_ILLEGAL;
    a_sel       = A_RS;
    b_sel       = B_SEXT;
    dec_illegal = 1'b0;
    if (bus.i_opcode == OPC_RTYPE) begin
      b_sel = B_RT;
      case (bus.i_funct)
        FN_ADD:  dec_op = ALU_ADD;
        FN_ADDU: dec_op = ALU_ADDU;
        FN_SUB:  dec_op = ALU_SUB;
        FN_SUBU: dec_op = ALU_SUBU;
        FN_AND:  dec_op = ALU_AND;
        FN_OR:   dec_op = ALU_OR;
        FN_XOR:  dec_op = ALU_XOR;
        FN_NOR:  dec_op = ALU_NOR;
        FN_SLT:  dec_op = ALU_SLT;
        FN_SLLV: dec_op = ALU_SLLV;
        FN_SRLV: dec_op = ALU_SRLV;
        FN_SRAV: dec_op = ALU_SRAV;
        // Constant shifts: value to shift is rt, amount comes from shamt
        FN_SLL: begin dec_op = ALU_SLL; a_sel = A_RT; b_sel = B_SHAMT; end
        FN_SRL: begin dec_op = ALU_SRL; a_sel = A_RT; b_sel = B_SHAMT; end
        FN_SRA: begin dec_op = ALU_SRA; a_sel = A_RT; b_sel = B_SHAMT; end
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (bus.i_opcode)
        OPC_ADDI:  dec_op = ALU_ADD;
        OPC_ADDIU: dec_op = ALU_ADDU;
        OPC_SLTI:  dec_op = ALU_SLT;
        // Logical immediates are zero-extended
        OPC_ANDI: begin dec_op = ALU_AND; b_sel = B_ZEXT; end
        OPC_ORI:  begin dec_op = ALU_OR;  b_sel = B_ZEXT; end
        OPC_XORI: begin dec_op = ALU_XOR; b_sel = B_ZEXT; end
        OPC_LUI:  begin dec_op = ALU_LUI; a_sel = A_ZERO; b_sel = B_ZEXT; end
        // Branches compare the two registers via subtraction
        OPC_BEQ:  begin dec_op = ALU_SUB;  b_sel = B_RT; end
        OPC_BNE:  begin dec_op = ALU_SUBU; b_sel = B_RT; end
        OPC_LB:   dec_op = ALU_LB;
        OPC_LH:   dec_op = ALU_LH;
        OPC_LBU:  dec_op = ALU_LBU;
        OPC_LHU:  dec_op = ALU_LHU;
        // Word load and all stores just need the address sum
        OPC_LW, OPC_SB, OPC_SH, OPC_SW: dec_op = ALU_ADD;
        default:  dec_illegal = 1'b1;
      endcase
    end
    if (dec_illegal) begin
      dec_op = ALU_ILLEGAL;
      a_sel  = A_ZERO;
      b_sel  = B_ZERO;
    end
  end

  always_comb begin
    case (a_sel)
      A_RS:    dec_a = bus.i_rs_data;
      A_RT:    dec_a = bus.i_rt_data;
      default: dec_a = '0;
    endcase
    case (b_sel)
      B_RT:    dec_b = bus.i_rt_data;
      B_SHAMT: dec_b = zext5(bus.i_shamt);
      B_SEXT:  dec_b = sext16(bus.i_imm);
      B_ZEXT:  dec_b = zext16(bus.i_imm);
      default: dec_b = '0;
    endcase
  end

  // ID/EX stage register
  logic                      valid_q,     valid_d;
  logic [N_BITS_CONTROL-1:0] alu_op_q,    alu_op_d;
  logic [NB_DATA-1:0]        data_a_q,    data_a_d;
  logic [NB_DATA-1:0]        data_b_q,    data_b_d;
  logic                      illegal_q,   illegal_d;
  logic                      ready;
  logic                      load;

  assign ready = !valid_q | bus.i_ready;
  assign load  = bus.i_valid & ready & !bus.i_flush;

  // Flush beats load and hold; a flushed slot keeps stale data, only the
  // control bits are cleared.
  always_comb begin
    valid_d   = valid_q;
    alu_op_d  = alu_op_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    illegal_d = illegal_q;
    if (bus.i_flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      alu_op_d  = dec_op;
      data_a_d  = dec_a;
      data_b_d  = dec_b;
      illegal_d = dec_illegal;
    end else if (valid_q & bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q   <= 1'b0;
      alu_op_q  <= ALU_ILLEGAL;
      data_a_q  <= '0;
      data_b_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      alu_op_q  <= alu_op_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_valid      = valid_q;
  assign bus.o_alu_opcode = alu_op_q;
  assign bus.o_data_a     = data_a_q;
  assign bus.o_data_b     = data_b_q;
  assign bus.o_illegal    = illegal_q;

`ifdef ALU_CTRL_ILLCNT_EN
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
    return (&v) ? v : v + NB_CNT'(1);
  endfunction

  // Illegal-instruction counter; survives flush, cleared only by reset
  logic [NB_CNT-1:0] ill_cnt_q, ill_cnt_d;

  always_comb begin
    ill_cnt_d = ill_cnt_q;
    if (load & dec_illegal) begin
      ill_cnt_d = sat_inc(ill_cnt_q);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ill_cnt_q <= '0;
    end else begin
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign bus.o_illegal_cnt = ill_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_ex_alu_ctrl
// Self-checking bench for id_ex_alu_ctrl: a table of decode vectors, hand
// sequences for stall / flush / drain / illegal counting, and randomized
// traffic compared against a cycle-level reference model of the stage.
// With ALU_CTRL_ILLCNT_EN the DUT is built with NB_CNT=2 to reach saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_alu_ctrl;
  localparam int NB_DATA = 32;
  localparam int NBC     = 5;
`ifdef ALU_CTRL_ILLCNT_EN
  localparam int NB_CNT  = 2;
`else
  localparam int NB_CNT  = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_alu_ctrl_if #(.NB_DATA(NB_DATA), .N_BITS_CONTROL(NBC), .NB_CNT(NB_CNT)) bus ();

  id_ex_alu_ctrl #(.NB_DATA(NB_DATA), .N_BITS_CONTROL(NBC), .NB_CNT(NB_CNT)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model state
  logic        m_valid = 1'b0;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b;
  logic        m_ill;
  logic        m_known = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", phase, name, act, exp);
    end
  endtask

  // Decode rules written straight from the instruction table
  function automatic void ref_decode(
    input  logic [5:0]  opc, fn,
    input  logic [4:0]  sh,
    input  logic [15:0] imm,
    input  logic [31:0] rs, rt,
    output logic [4:0]  op,
    output logic [31:0] a, b,
    output logic        ill);
    logic [31:0] se, ze;
    se  = {{16{imm[15]}}, imm};
    ze  = {16'h0000, imm};
    ill = 1'b0;
    op  = 5'h1F;
    a   = rs;
    b   = se;
    if (opc == 6'd0) begin
      b = rt;
      case (fn)
        6'h20: op = 5'b00010;
        6'h21: op = 5'b00011;
        6'h22: op = 5'b00111;
        6'h23: op = 5'b01000;
        6'h24: op = 5'b00000;
        6'h25: op = 5'b00001;
        6'h26: op = 5'b00101;
        6'h27: op = 5'b00100;
        6'h2A: op = 5'b01001;
        6'h00: begin op = 5'b00110; a = rt; b = {27'd0, sh}; end
        6'h02: begin op = 5'b01010; a = rt; b = {27'd0, sh}; end
        6'h03: begin op = 5'b01011; a = rt; b = {27'd0, sh}; end
        6'h04: op = 5'b10010;
        6'h06: op = 5'b10011;
        6'h07: op = 5'b10001;
        default: ill = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h08: op = 5'b00010;
        6'h09: op = 5'b00011;
        6'h0A: op = 5'b01001;
        6'h0C: begin op = 5'b00000; b = ze; end
        6'h0D: begin op = 5'b00001; b = ze; end
        6'h0E: begin op = 5'b00101; b = ze; end
        6'h0F: begin op = 5'b01100; a = 0; b = ze; end
        6'h04: begin op = 5'b00111; b = rt; end
        6'h05: begin op = 5'b01000; b = rt; end
        6'h20: op = 5'b01101;
        6'h21: op = 5'b01110;
        6'h24: op = 5'b01111;
        6'h25: op = 5'b10000;
        6'h23, 6'h28, 6'h29, 6'h2B: op = 5'b00010;
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      op = 5'h1F;
      a  = 0;
      b  = 0;
    end
  endfunction

  // One clock: check o_ready, advance the model with the current inputs,
  // then compare the registered outputs after the edge.
  task automatic cycle();
    logic [4:0]  dop;
    logic [31:0] da, db;
    logic        dill, rdy;
    #1;
    rdy = !m_valid || bus.i_ready;
    if (!rst) chk("o_ready", {31'd0, bus.o_ready}, {31'd0, rdy});
    ref_decode(bus.i_opcode, bus.i_funct, bus.i_shamt, bus.i_imm,
               bus.i_rs_data, bus.i_rt_data, dop, da, db, dill);
    if (rst) begin
      m_valid = 0; m_op = 5'h1F; m_a = 0; m_b = 0; m_ill = 0; m_known = 1; m_cnt = 0;
    end else if (bus.i_flush) begin
      m_valid = 0; m_ill = 0; m_known = 0;
    end else if (bus.i_valid && rdy) begin
      m_valid = 1; m_op = dop; m_a = da; m_b = db; m_ill = dill; m_known = 1;
      if (dill && m_cnt < (2**NB_CNT) - 1) m_cnt++;
    end else if (m_valid && bus.i_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("o_valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
    chk("o_illegal", {31'd0, bus.o_illegal}, {31'd0, m_ill});
    if (m_known) begin
      chk("o_alu_opcode", {27'd0, bus.o_alu_opcode}, {27'd0, m_op});
      chk("o_data_a", bus.o_data_a, m_a);
      chk("o_data_b", bus.o_data_b, m_b);
    end
`ifdef ALU_CTRL_ILLCNT_EN
    chk("o_illegal_cnt", 32'(bus.o_illegal_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    bus.i_opcode  = opc;
    bus.i_funct   = fn;
    bus.i_shamt   = sh;
    bus.i_imm     = imm;
    bus.i_rs_data = rs;
    bus.i_rt_data = rt;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_ill;
  } vec_t;

  vec_t vecs[16];

  logic [5:0] opc_pool[19];
  logic [5:0] fn_pool[16];

  initial begin
    vecs[0]  = '{"sub",     6'h00, 6'h22, 5'd0,  16'h0000, 32'd10,        32'd3,   5'b00111, 32'd10,        32'd3,         1'b0};
    vecs[1]  = '{"sll",     6'h00, 6'h00, 5'd4,  16'h0000, 32'd99,        32'd1,   5'b00110, 32'd1,         32'd4,         1'b0};
    vecs[2]  = '{"addi",    6'h08, 6'h00, 5'd0,  16'hFFFF, 32'd5,         32'd0,   5'b00010, 32'd5,         32'hFFFFFFFF,  1'b0};
    vecs[3]  = '{"ori",     6'h0D, 6'h00, 5'd0,  16'hFFFF, 32'd5,         32'd0,   5'b00001, 32'd5,         32'h0000FFFF,  1'b0};
    vecs[4]  = '{"lui",     6'h0F, 6'h00, 5'd0,  16'h1234, 32'd7,         32'd0,   5'b01100, 32'd0,         32'h00001234,  1'b0};
    vecs[5]  = '{"ill_opc", 6'h3F, 6'h00, 5'd0,  16'h5555, 32'd1,         32'd2,   5'b11111, 32'd0,         32'd0,         1'b1};
    vecs[6]  = '{"beq",     6'h04, 6'h00, 5'd0,  16'h0008, 32'd9,         32'd9,   5'b00111, 32'd9,         32'd9,         1'b0};
    vecs[7]  = '{"lw",      6'h23, 6'h00, 5'd0,  16'hFFFC, 32'h100,       32'd0,   5'b00010, 32'h100,       32'hFFFFFFFC,  1'b0};
    vecs[8]  = '{"sra",     6'h00, 6'h03, 5'd31, 16'h0000, 32'd5,         32'h80000000, 5'b01011, 32'h80000000, 32'd31,   1'b0};
    vecs[9]  = '{"srav",    6'h00, 6'h07, 5'd0,  16'h0000, 32'd4,         32'hF0,  5'b10001, 32'd4,         32'hF0,        1'b0};
    vecs[10] = '{"ill_fn",  6'h00, 6'h01, 5'd0,  16'h0000, 32'd8,         32'd8,   5'b11111, 32'd0,         32'd0,         1'b1};
    vecs[11] = '{"lhu",     6'h25, 6'h00, 5'd0,  16'h8000, 32'h10,        32'd0,   5'b10000, 32'h10,        32'hFFFF8000,  1'b0};
    vecs[12] = '{"slti",    6'h0A, 6'h00, 5'd0,  16'h7FFF, 32'hDEAD,      32'd0,   5'b01001, 32'hDEAD,      32'h00007FFF,  1'b0};
    vecs[13] = '{"nor",     6'h00, 6'h27, 5'd0,  16'h0000, 32'hAAAA5555,  32'h1,   5'b00100, 32'hAAAA5555,  32'h1,         1'b0};
    vecs[14] = '{"xori",    6'h0E, 6'h00, 5'd0,  16'h8001, 32'd3,         32'd0,   5'b00101, 32'd3,         32'h00008001,  1'b0};
    vecs[15] = '{"sb",      6'h28, 6'h00, 5'd0,  16'h0004, 32'd40,        32'd0,   5'b00010, 32'd40,        32'd4,         1'b0};

    opc_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                 6'h04, 6'h05, 6'h20, 6'h21, 6'h24, 6'h25, 6'h23, 6'h2B, 6'h3F};
    fn_pool  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01};

    // Reset
    phase = "reset";
    rst = 1'b1;
    bus.i_valid = 0; bus.i_ready = 0; bus.i_flush = 0;
    set_instr(6'h00, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0);
    cycle();
    cycle();
    chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_op", {27'd0, bus.o_alu_opcode}, 32'h1F);
    chk("rst_a", bus.o_data_a, 32'd0);
    chk("rst_b", bus.o_data_b, 32'd0);
    chk("rst_ill", {31'd0, bus.o_illegal}, 32'd0);
    rst = 1'b0;

    // Table vectors, back to back with i_ready high
    bus.i_ready = 1; bus.i_valid = 1;
    foreach (vecs[i]) begin
      phase = vecs[i].name;
      set_instr(vecs[i].opc, vecs[i].fn, vecs[i].sh, vecs[i].imm, vecs[i].rs, vecs[i].rt);
      cycle();
      chk("vec_valid", {31'd0, bus.o_valid}, 32'd1);
      chk("vec_op", {27'd0, bus.o_alu_opcode}, {27'd0, vecs[i].e_op});
      chk("vec_a", bus.o_data_a, vecs[i].e_a);
      chk("vec_b", bus.o_data_b, vecs[i].e_b);
      chk("vec_ill", {31'd0, bus.o_illegal}, {31'd0, vecs[i].e_ill});
    end

    // Stall: lw held while addu waits upstream
    phase = "stall";
    set_instr(6'h23, 6'h00, 5'd0, 16'h0010, 32'h200, 32'd0);
    cycle();
    bus.i_ready = 0;
    set_instr(6'h00, 6'h21, 5'd0, 16'h0, 32'd11, 32'd22);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_ready", {31'd0, bus.o_ready}, 32'd0);
      chk("stall_op", {27'd0, bus.o_alu_opcode}, 32'h02);
      chk("stall_b", bus.o_data_b, 32'h10);
    end
    bus.i_ready = 1;
    cycle();
    chk("addu_op", {27'd0, bus.o_alu_opcode}, 32'h03);
    chk("addu_a", bus.o_data_a, 32'd11);

    // Drain: valid drops, data kept
    phase = "drain";
    bus.i_valid = 0;
    cycle();
    chk("drain_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("drain_op", {27'd0, bus.o_alu_opcode}, 32'h03);

    // Flush with a simultaneous valid instruction
    phase = "flush_valid";
    bus.i_valid = 1; bus.i_flush = 1;
    set_instr(6'h08, 6'h00, 5'd0, 16'h0001, 32'd1, 32'd0);
    cycle();
    chk("flush_valid", {31'd0, bus.o_valid}, 32'd0);

    // Flush while stalled on an illegal op
    phase = "flush_stall";
    bus.i_flush = 0;
    set_instr(6'h3E, 6'h00, 5'd0, 16'h0, 32'd1, 32'd1);
    cycle();
    bus.i_ready = 0; bus.i_valid = 0;
    cycle();
    chk("stalled_ill", {31'd0, bus.o_illegal}, 32'd1);
    bus.i_flush = 1;
    cycle();
    chk("flush_stall_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("flush_stall_ill", {31'd0, bus.o_illegal}, 32'd0);
    bus.i_flush = 0; bus.i_ready = 1;

`ifdef ALU_CTRL_ILLCNT_EN
    // Illegal counter: 3 loads reach 3, two more saturate at 3 (NB_CNT=2)
    phase = "illcnt";
    rst = 1; cycle(); rst = 0;
    bus.i_valid = 1;
    set_instr(6'h3F, 6'h00, 5'd0, 16'h0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) cycle();
    chk("cnt_3", 32'(bus.o_illegal_cnt), 32'd3);
    bus.i_flush = 1; cycle(); bus.i_flush = 0;
    chk("cnt_after_flush", 32'(bus.o_illegal_cnt), 32'd3);
    for (int k = 0; k < 2; k++) cycle();
    chk("cnt_sat", 32'(bus.o_illegal_cnt), 32'd3);
    bus.i_valid = 0;
`endif

    // Randomized traffic against the model
    phase = "random";
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      bus.i_valid = ($urandom_range(0, 3) != 0);
      bus.i_ready = ($urandom_range(0, 3) != 0);
      bus.i_flush = ($urandom_range(0, 15) == 0);
      set_instr(($urandom_range(0, 9) == 0) ? 6'($urandom) : opc_pool[$urandom_range(0, 18)],
                ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 15)],
                5'($urandom), 16'($urandom), $urandom, $urandom);
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_ctrl.md
Name: id_ex_alu_ctrl

Overview:
- Decode-side producer for the ALU: turns a MIPS instruction's opcode/funct plus register operands into the 5-bit ALU operation code and operand pair, held in a registered ID/EX pipeline stage.
- Sits between the register-file read in ID and the ALU input in EX.
- Uses a valid/ready handshake with stall and flush so hazard logic can freeze or squash the stage.

Parameters:
- NB_DATA, 32, operand/result width.
- N_BITS_CONTROL, 5, ALU operation code width.
- NB_CNT, 16, width of the illegal-instruction counter (optional feature only).

Ports:
- i_clock  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; combinational = !o_valid | i_ready.
- i_opcode  in  6  instr[31:26].
- i_funct  in  6  instr[5:0].
- i_shamt  in  5  instr[10:6].
- i_imm  in  16  instr[15:0].
- i_rs_data  in  NB_DATA  rs read value.
- i_rt_data  in  NB_DATA  rt read value.
- i_ready  in  1  EX stage accepts.
- i_flush  in  1  squash stage content.
- o_valid  out  1  stage holds a valid op.
- o_alu_opcode  out  N_BITS_CONTROL  ALU operation.
- o_data_a  out  NB_DATA  ALU operand A.
- o_data_b  out  NB_DATA  ALU operand B.
- o_illegal  out  1  held op was undecodable.
- o_illegal_cnt  out  NB_CNT  present only with ALU_CTRL_ILLCNT_EN.

Behaviour:
- Reset (sync): o_valid=0, o_alu_opcode=5'b11111, o_data_a=0, o_data_b=0, o_illegal=0, counter=0.
- Load condition: load = i_valid & o_ready & !i_flush.
  - On load: decoded fields are registered; o_valid=1 on the next edge. Latency is 1 cycle.
- Hold: if o_valid & !i_ready & !i_flush, all outputs hold (stall).
- Drain: if o_valid & i_ready & !(i_valid) & !i_flush, o_valid goes 0 next cycle; data registers keep their last value.
- Flush: i_flush has priority over load and hold.
  - Next cycle: o_valid=0, o_illegal=0; data registers are don't-care.
  - A simultaneous i_valid is dropped; upstream must resend.
- Reset has priority over flush.
- Decode, opcode 000000 (R-type, by funct):
  - 100000 add -> 00010, A=rs, B=rt.
  - 100001 addu -> 00011.
  - 100010 sub -> 00111.
  - 100011 subu -> 01000.
  - 100100 and -> 00000.
  - 100101 or -> 00001.
  - 100110 xor -> 00101.
  - 100111 nor -> 00100.
  - 101010 slt -> 01001.
  - 000000 sll -> 00110, A=rt, B=zext(shamt).
  - 000010 srl -> 01010, A=rt, B=zext(shamt).
  - 000011 sra -> 01011, A=rt, B=zext(shamt).
  - 000100 sllv -> 10010, A=rs, B=rt.
  - 000110 srlv -> 10011, A=rs, B=rt.
  - 000111 srav -> 10001, A=rs, B=rt.
- Decode, I-type (A=rs, B=sext(imm) unless stated):
  - 001000 addi -> 00010.
  - 001001 addiu -> 00011.
  - 001010 slti -> 01001.
  - 001100 andi -> 00000, B=zext(imm).
  - 001101 ori -> 00001, B=zext(imm).
  - 001110 xori -> 00101, B=zext(imm).
  - 001111 lui -> 01100, A=0, B=zext(imm).
  - 000100 beq -> 00111, B=rt.
  - 000101 bne -> 01000, B=rt.
  - 100000 lb -> 01101.
  - 100001 lh -> 01110.
  - 100100 lbu -> 01111.
  - 100101 lhu -> 10000.
  - 100011 lw, 101000 sb, 101001 sh, 101011 sw -> 00010.
- Illegal: any other opcode/funct combination.
  - Registered as o_alu_opcode=11111, A=B=0, o_illegal=1, o_valid=1; the ALU then yields 0/zero.
- Back-to-back: with i_ready held 1, one instruction is accepted per cycle and no bubbles are inserted.

Optional Feature:
- Macro ALU_CTRL_ILLCNT_EN.
- Defined:
  - Port o_illegal_cnt exists.
  - Increments by 1 on each load that decodes as illegal.
  - Saturates at all-ones.
  - Cleared only by i_reset; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert i_reset 2 cycles -> o_valid=0, o_alu_opcode=11111, o_data_a=o_data_b=0, o_illegal=0.
- R-type sub: opcode 000000, funct 100010, rs=10, rt=3, i_ready=1 -> next cycle o_valid=1, opcode 00111, A=10, B=3. Shift: sll with shamt=4, rt=1 -> opcode 00110, A=1, B=4.
- Immediate extension: addi with imm 16'hFFFF -> B=32'hFFFFFFFF. ori with imm 16'hFFFF -> B=32'h0000FFFF. lui with imm 16'h1234 -> opcode 01100, A=0, B=32'h00001234.
- Stall: load lw, then hold i_ready=0 for 3 cycles while upstream presents addu -> outputs stay lw/00010 and o_ready=0; addu is accepted only after i_ready returns to 1.
- Flush: i_flush=1 together with i_valid=1 -> next cycle o_valid=0. Flush while stalled -> o_valid=0 next cycle.
- Illegal: opcode 111111 -> o_illegal=1, opcode 11111, A=B=0. With ALU_CTRL_ILLCNT_EN, 3 illegal loads -> o_illegal_cnt=3; with NB_CNT=2, 5 illegal loads -> o_illegal_cnt=3 (saturated).
